// File: rtl/n_set_cache_pkg.sv
// Shared types and default geometry for the n-set cache miss sequencer.
package n_set_cache_pkg;

   localparam int DEF_CACHE_BLOCK_CAPACITY = 128;
   localparam int DEF_CACHE_SET_SIZE       = 4;
   localparam int DEF_BW_TAG               = 20;

   localparam int DEF_BW_CACHE_CAPACITY = $clog2(DEF_CACHE_BLOCK_CAPACITY);
   localparam int DEF_BW_GRP            = $clog2(DEF_CACHE_SET_SIZE);
   localparam int DEF_BW_SET            = DEF_BW_CACHE_CAPACITY - DEF_BW_GRP;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POLICY = 3'd1,
      WB     = 3'd2,
      FETCH  = 3'd3,
      FILL   = 3'd4
   } state_t;

endpackage

// File: rtl/n_set_cache_miss_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; used by the optional
// N_SET_CACHE_MISS_SEQ_PERF_EN statistics.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count up on inc, holding at all-ones.
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= {WIDTH{1'b0}};
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/n_set_cache_miss_sequencer.sv
// Miss sequencer driving the n-set replacement policy and the memory port.
// Optional statistics counters enabled by `define N_SET_CACHE_MISS_SEQ_PERF_EN.
module n_set_cache_miss_sequencer
   import n_set_cache_pkg::*;
#(
   parameter int  CACHE_BLOCK_CAPACITY = DEF_CACHE_BLOCK_CAPACITY,
   parameter int  CACHE_SET_SIZE       = DEF_CACHE_SET_SIZE,
   parameter int  BW_TAG               = DEF_BW_TAG,
   localparam int BW_CACHE_CAPACITY    = $clog2(CACHE_BLOCK_CAPACITY),
   localparam int BW_GRP               = $clog2(CACHE_SET_SIZE),
   localparam int BW_SET               = BW_CACHE_CAPACITY - BW_GRP,
   localparam int BW_MEM               = BW_TAG + BW_SET
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   input  logic                         req_i,
   input  logic                         hit_i,
   input  logic [BW_SET-1:0]            set_i,
   input  logic [BW_TAG-1:0]            tag_i,
   input  logic [BW_CACHE_CAPACITY-1:0] hit_addr_i,
   output logic                         policy_hit_o,
   output logic                         policy_miss_o,
   output logic [BW_CACHE_CAPACITY-1:0] policy_addr_o,
   input  logic                         policy_done_i,
   input  logic [BW_CACHE_CAPACITY-1:0] policy_addr_i,
   input  logic                         victim_dirty_i,
   input  logic [BW_TAG-1:0]            victim_tag_i,
   output logic                         mem_req_o,
   output logic                         mem_rw_o,
   output logic [BW_MEM-1:0]            mem_addr_o,
   input  logic                         mem_ack_i,
   output logic                         fill_o,
   output logic [BW_CACHE_CAPACITY-1:0] fill_addr_o,
   output logic [BW_TAG-1:0]            fill_tag_o,
   output logic                         busy_o,
   output logic                         done_o
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
   ,
   output logic [31:0]                  hit_count_o,
   output logic [31:0]                  miss_count_o,
   output logic [31:0]                  wb_count_o
`endif
);

   state_t state;
   state_t next_state;

   logic [BW_SET-1:0]            req_set;
   logic [BW_TAG-1:0]            req_tag;
   logic [BW_CACHE_CAPACITY-1:0] vic_addr;
   logic [BW_TAG-1:0]            vic_tag;
   logic [BW_SET-1:0]            req_set_nxt;
   logic [BW_TAG-1:0]            req_tag_nxt;
   logic [BW_CACHE_CAPACITY-1:0] vic_addr_nxt;
   logic [BW_TAG-1:0]            vic_tag_nxt;

   logic                         policy_hit_nxt;
   logic                         policy_miss_nxt;
   logic [BW_CACHE_CAPACITY-1:0] policy_addr_nxt;
   logic                         mem_req_nxt;
   logic                         mem_rw_nxt;
   logic [BW_MEM-1:0]            mem_addr_nxt;
   logic                         fill_nxt;
   logic [BW_CACHE_CAPACITY-1:0] fill_addr_nxt;
   logic [BW_TAG-1:0]            fill_tag_nxt;
   logic                         busy_nxt;
   logic                         done_nxt;

   logic hit_start;
   logic miss_start;

   // Requests are only looked at in IDLE; upstream stalls while busy.
   assign hit_start  = (state == IDLE) && req_i && hit_i;
   assign miss_start = (state == IDLE) && req_i && !hit_i;

   // State and captured request/victim registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state    <= IDLE;
         req_set  <= {BW_SET{1'b0}};
         req_tag  <= {BW_TAG{1'b0}};
         vic_addr <= {BW_CACHE_CAPACITY{1'b0}};
         vic_tag  <= {BW_TAG{1'b0}};
      end else begin
         state    <= next_state;
         req_set  <= req_set_nxt;
         req_tag  <= req_tag_nxt;
         vic_addr <= vic_addr_nxt;
         vic_tag  <= vic_tag_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = miss_start ? POLICY : IDLE;
         POLICY: begin
            if (policy_done_i) begin
               next_state = victim_dirty_i ? WB : FETCH;
            end else begin
               next_state = POLICY;
            end
         end
         WB:      next_state = mem_ack_i ? FETCH : WB;
         FETCH:   next_state = mem_ack_i ? FILL : FETCH;
         FILL:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture values; outputs are derived from these so they line up with the new state.
   always_comb begin
      req_set_nxt  = req_set;
      req_tag_nxt  = req_tag;
      vic_addr_nxt = vic_addr;
      vic_tag_nxt  = vic_tag;
      if (miss_start) begin
         req_set_nxt = set_i;
         req_tag_nxt = tag_i;
      end else begin
         req_set_nxt = req_set;
         req_tag_nxt = req_tag;
      end
      if ((state == POLICY) && policy_done_i) begin
         vic_addr_nxt = policy_addr_i;
         vic_tag_nxt  = victim_tag_i;
      end else begin
         vic_addr_nxt = vic_addr;
         vic_tag_nxt  = vic_tag;
      end
   end

   // Output decode for the coming cycle.
   always_comb begin
      policy_hit_nxt  = hit_start;
      policy_miss_nxt = miss_start;
      policy_addr_nxt = {BW_CACHE_CAPACITY{1'b0}};
      mem_req_nxt     = 1'b0;
      mem_rw_nxt      = 1'b0;
      mem_addr_nxt    = {BW_MEM{1'b0}};
      fill_nxt        = 1'b0;
      fill_addr_nxt   = {BW_CACHE_CAPACITY{1'b0}};
      fill_tag_nxt    = {BW_TAG{1'b0}};
      busy_nxt        = (next_state != IDLE);
      done_nxt        = 1'b0;
      if (hit_start) begin
         policy_addr_nxt = hit_addr_i;
      end else if (next_state == POLICY) begin
         policy_addr_nxt = {{BW_GRP{1'b0}}, req_set_nxt};
      end else begin
         policy_addr_nxt = {BW_CACHE_CAPACITY{1'b0}};
      end
      case (next_state)
         WB: begin
            mem_req_nxt  = 1'b1;
            mem_rw_nxt   = 1'b1;
            mem_addr_nxt = {vic_tag_nxt, req_set_nxt};
         end
         FETCH: begin
            mem_req_nxt  = 1'b1;
            mem_rw_nxt   = 1'b0;
            mem_addr_nxt = {req_tag_nxt, req_set_nxt};
         end
         FILL: begin
            fill_nxt      = 1'b1;
            fill_addr_nxt = vic_addr_nxt;
            fill_tag_nxt  = req_tag_nxt;
            done_nxt      = 1'b1;
         end
         default: begin
            mem_req_nxt = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         policy_hit_o  <= 1'b0;
         policy_miss_o <= 1'b0;
         policy_addr_o <= {BW_CACHE_CAPACITY{1'b0}};
         mem_req_o     <= 1'b0;
         mem_rw_o      <= 1'b0;
         mem_addr_o    <= {BW_MEM{1'b0}};
         fill_o        <= 1'b0;
         fill_addr_o   <= {BW_CACHE_CAPACITY{1'b0}};
         fill_tag_o    <= {BW_TAG{1'b0}};
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         policy_hit_o  <= policy_hit_nxt;
         policy_miss_o <= policy_miss_nxt;
         policy_addr_o <= policy_addr_nxt;
         mem_req_o     <= mem_req_nxt;
         mem_rw_o      <= mem_rw_nxt;
         mem_addr_o    <= mem_addr_nxt;
         fill_o        <= fill_nxt;
         fill_addr_o   <= fill_addr_nxt;
         fill_tag_o    <= fill_tag_nxt;
         busy_o        <= busy_nxt;
         done_o        <= done_nxt;
      end
   end

`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
   logic wb_ack;
   assign wb_ack = (state == WB) && mem_ack_i;

   sat_counter #(.WIDTH(32)) u_hit_count (
      .clk   (clock_i),
      .clear (reset_i),
      .inc   (policy_hit_nxt),
      .count (hit_count_o)
   );

   sat_counter #(.WIDTH(32)) u_miss_count (
      .clk   (clock_i),
      .clear (reset_i),
      .inc   (policy_miss_nxt),
      .count (miss_count_o)
   );

   sat_counter #(.WIDTH(32)) u_wb_count (
      .clk   (clock_i),
      .clear (reset_i),
      .inc   (wb_ack),
      .count (wb_count_o)
   );
`endif

endmodule

// File: tb/tb_n_set_cache_miss_sequencer.sv
// Directed bench for n_set_cache_miss_sequencer; perf counters checked when
// N_SET_CACHE_MISS_SEQ_PERF_EN is defined.
module tb_n_set_cache_miss_sequencer;

   logic        clock = 1'b0;
   logic        reset_i;
   logic        req_i;
   logic        hit_i;
   logic [4:0]  set_i;
   logic [19:0] tag_i;
   logic [6:0]  hit_addr_i;
   logic        policy_hit_o;
   logic        policy_miss_o;
   logic [6:0]  policy_addr_o;
   logic        policy_done_i;
   logic [6:0]  policy_addr_i;
   logic        victim_dirty_i;
   logic [19:0] victim_tag_i;
   logic        mem_req_o;
   logic        mem_rw_o;
   logic [24:0] mem_addr_o;
   logic        mem_ack_i;
   logic        fill_o;
   logic [6:0]  fill_addr_o;
   logic [19:0] fill_tag_o;
   logic        busy_o;
   logic        done_o;
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
   logic [31:0] hit_count_o;
   logic [31:0] miss_count_o;
   logic [31:0] wb_count_o;
   logic        sc_inc;
   logic [1:0]  sc_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   n_set_cache_miss_sequencer dut (
      .clock_i        (clock),
      .reset_i        (reset_i),
      .req_i          (req_i),
      .hit_i          (hit_i),
      .set_i          (set_i),
      .tag_i          (tag_i),
      .hit_addr_i     (hit_addr_i),
      .policy_hit_o   (policy_hit_o),
      .policy_miss_o  (policy_miss_o),
      .policy_addr_o  (policy_addr_o),
      .policy_done_i  (policy_done_i),
      .policy_addr_i  (policy_addr_i),
      .victim_dirty_i (victim_dirty_i),
      .victim_tag_i   (victim_tag_i),
      .mem_req_o      (mem_req_o),
      .mem_rw_o       (mem_rw_o),
      .mem_addr_o     (mem_addr_o),
      .mem_ack_i      (mem_ack_i),
      .fill_o         (fill_o),
      .fill_addr_o    (fill_addr_o),
      .fill_tag_o     (fill_tag_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
      ,
      .hit_count_o    (hit_count_o),
      .miss_count_o   (miss_count_o),
      .wb_count_o     (wb_count_o)
`endif
   );

`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
   sat_counter #(.WIDTH(2)) u_sat (
      .clk   (clock),
      .clear (reset_i),
      .inc   (sc_inc),
      .count (sc_count)
   );
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_req(input logic hit, input logic [4:0] s, input logic [19:0] t,
                            input logic [6:0] ha);
      req_i      = 1'b1;
      hit_i      = hit;
      set_i      = s;
      tag_i      = t;
      hit_addr_i = ha;
      tick();
      req_i      = 1'b0;
      hit_i      = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1; req_i = 1'b0; hit_i = 1'b0; set_i = 5'h00; tag_i = 20'h00000;
      hit_addr_i = 7'h00; policy_done_i = 1'b0; policy_addr_i = 7'h00;
      victim_dirty_i = 1'b0; victim_tag_i = 20'h00000; mem_ack_i = 1'b0;
`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
      sc_inc = 1'b0;
`endif
      tick();
      tick();
      check("rst_busy", busy_o, 1'b0);
      check("rst_mem_req", mem_req_o, 1'b0);
      check("rst_fill", fill_o, 1'b0);
      check("rst_policy_addr", policy_addr_o, 7'h00);
      reset_i = 1'b0;
      tick();

      // Hit
      start_req(1'b1, 5'h00, 20'h00000, 7'h25);
      check("hit_pulse", policy_hit_o, 1'b1);
      check("hit_addr", policy_addr_o, 7'h25);
      check("hit_mem_req", mem_req_o, 1'b0);
      check("hit_busy", busy_o, 1'b0);
      tick();
      check("hit_one_cycle", policy_hit_o, 1'b0);

      // Clean miss, ack after 5 request cycles
      policy_done_i = 1'b1; policy_addr_i = 7'h43; victim_dirty_i = 1'b0;
      victim_tag_i = 20'h0F0F0;
      start_req(1'b0, 5'h03, 20'hABCDE, 7'h00);
      check("cm_miss_pulse", policy_miss_o, 1'b1);
      check("cm_policy_addr", policy_addr_o, 7'h03);
      check("cm_busy", busy_o, 1'b1);
      check("cm_no_req_in_policy", mem_req_o, 1'b0);
      tick();
      policy_done_i = 1'b0;
      check("cm_miss_cleared", policy_miss_o, 1'b0);
      check("cm_fetch_req", mem_req_o, 1'b1);
      check("cm_fetch_rw", mem_rw_o, 1'b0);
      check("cm_fetch_addr", mem_addr_o, {20'hABCDE, 5'h03});
      for (int i = 0; i < 4; i++) begin
         tick();
         check("cm_req_held", mem_req_o, 1'b1);
      end
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      check("cm_fill", fill_o, 1'b1);
      check("cm_fill_addr", fill_addr_o, 7'h43);
      check("cm_fill_tag", fill_tag_o, 20'hABCDE);
      check("cm_done", done_o, 1'b1);
      check("cm_req_dropped", mem_req_o, 1'b0);
      tick();
      check("cm_done_one_cycle", done_o, 1'b0);
      check("cm_fill_one_cycle", fill_o, 1'b0);
      check("cm_idle", busy_o, 1'b0);

      // Dirty miss, ack held high across WB and FETCH
      policy_done_i = 1'b1; policy_addr_i = 7'h43; victim_dirty_i = 1'b1;
      victim_tag_i = 20'h12345;
      start_req(1'b0, 5'h03, 20'hABCDE, 7'h00);
      tick();
      policy_done_i = 1'b0; victim_dirty_i = 1'b0;
      check("dm_wb_req", mem_req_o, 1'b1);
      check("dm_wb_rw", mem_rw_o, 1'b1);
      check("dm_wb_addr", mem_addr_o, {20'h12345, 5'h03});
      mem_ack_i = 1'b1;
      tick();
      check("dm_fetch_req", mem_req_o, 1'b1);
      check("dm_fetch_rw", mem_rw_o, 1'b0);
      check("dm_fetch_addr", mem_addr_o, {20'hABCDE, 5'h03});
      tick();
      check("dm_fill", fill_o, 1'b1);
      check("dm_fill_addr", fill_addr_o, 7'h43);
      check("dm_req_dropped", mem_req_o, 1'b0);
      tick();
      mem_ack_i = 1'b0;
      check("dm_idle_ack_ignored", mem_req_o, 1'b0);
      check("dm_idle_busy", busy_o, 1'b0);

      // Policy stall for 3 cycles
      policy_done_i = 1'b0; policy_addr_i = 7'h11;
      start_req(1'b0, 5'h1F, 20'h55555, 7'h00);
      check("ps_miss_first", policy_miss_o, 1'b1);
      check("ps_addr", policy_addr_o, 7'h1F);
      tick();
      check("ps_miss_only_first", policy_miss_o, 1'b0);
      check("ps_no_req", mem_req_o, 1'b0);
      check("ps_addr_held", policy_addr_o, 7'h1F);
      tick();
      check("ps_no_req2", mem_req_o, 1'b0);
      check("ps_busy", busy_o, 1'b1);
      policy_done_i = 1'b1;
      tick();
      policy_done_i = 1'b0;
      check("ps_fetch_req", mem_req_o, 1'b1);
      check("ps_fetch_addr", mem_addr_o, {20'h55555, 5'h1F});
      check("ps_policy_addr_cleared", policy_addr_o, 7'h00);

      // Reset while in FETCH
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("rf_mem_req", mem_req_o, 1'b0);
      check("rf_busy", busy_o, 1'b0);
      check("rf_fill", fill_o, 1'b0);
      check("rf_done", done_o, 1'b0);
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      check("rf_no_fill_after", fill_o, 1'b0);
      check("rf_no_done_after", done_o, 1'b0);
      start_req(1'b1, 5'h00, 20'h00000, 7'h5A);
      check("rf_hit_pulse", policy_hit_o, 1'b1);
      check("rf_hit_addr", policy_addr_o, 7'h5A);

      // Extra traffic: two more hits, one clean and one dirty miss
      start_req(1'b1, 5'h00, 20'h00000, 7'h01);
      start_req(1'b1, 5'h00, 20'h00000, 7'h02);
      policy_done_i = 1'b1; policy_addr_i = 7'h22; victim_dirty_i = 1'b0;
      start_req(1'b0, 5'h02, 20'h00002, 7'h00);
      tick();
      policy_done_i = 1'b0;
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      check("x1_fill_addr", fill_addr_o, 7'h22);
      tick();
      policy_done_i = 1'b1; policy_addr_i = 7'h63; victim_dirty_i = 1'b1;
      victim_tag_i = 20'hFEDCB;
      start_req(1'b0, 5'h04, 20'h00004, 7'h00);
      tick();
      policy_done_i = 1'b0; victim_dirty_i = 1'b0;
      check("x2_wb_addr", mem_addr_o, {20'hFEDCB, 5'h04});
      mem_ack_i = 1'b1;
      tick();
      tick();
      mem_ack_i = 1'b0;
      check("x2_fill_tag", fill_tag_o, 20'h00004);
      check("x2_fill_addr", fill_addr_o, 7'h63);
      tick();

`ifdef N_SET_CACHE_MISS_SEQ_PERF_EN
      check("perf_hits", hit_count_o, 32'd3);
      check("perf_misses", miss_count_o, 32'd2);
      check("perf_wbs", wb_count_o, 32'd1);
      sc_inc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      sc_inc = 1'b0;
      check("sat_hold", sc_count, 2'b11);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/n_set_cache_miss_sequencer.md
Name: n_set_cache_miss_sequencer

Overview:
Cache-controller-side initiator for the n-set replacement policy interface. Drives the policy controller's hit/miss/address inputs and consumes its done/victim-address outputs. On a miss it obtains a victim, optionally writes back a dirty victim, fetches the new block, and issues a one-cycle fill to the tag/data store. Sits between the tag lookup stage and the memory-side port, one instance per cache.

Parameters:
CACHE_BLOCK_CAPACITY, 128, total cache blocks; BW_CACHE_CAPACITY = CLOG2(value)
CACHE_SET_SIZE, 4, ways per set; BW_GRP = CLOG2(value), BW_SET = BW_CACHE_CAPACITY-BW_GRP
BW_TAG, 20, tag width; memory block address width = BW_TAG+BW_SET

Ports:
clock_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
req_i  in  1  lookup result valid this cycle
hit_i  in  1  lookup hit, qualified by req_i
set_i  in  BW_SET  set index of request
tag_i  in  BW_TAG  tag of request
hit_addr_i  in  BW_CACHE_CAPACITY  {group,set} of hitting block
policy_hit_o  out  1  to policy controller hit input
policy_miss_o  out  1  to policy controller miss input
policy_addr_o  out  BW_CACHE_CAPACITY  to policy controller address input
policy_done_i  in  1  victim address valid
policy_addr_i  in  BW_CACHE_CAPACITY  victim {group,set}
victim_dirty_i  in  1  dirty bit of block at policy_addr_i
victim_tag_i  in  BW_TAG  tag of block at policy_addr_i
mem_req_o  out  1  memory request, level until ack
mem_rw_o  out  1  1=write-back, 0=fetch
mem_addr_o  out  BW_TAG+BW_SET  {tag,set} block address
mem_ack_i  in  1  request consumed
fill_o  out  1  one-cycle fill strobe
fill_addr_o  out  BW_CACHE_CAPACITY  block to fill
fill_tag_o  out  BW_TAG  tag to write
busy_o  out  1  miss in progress
done_o  out  1  one-cycle miss-complete pulse

Behaviour:
- Reset: state IDLE; all outputs 0; internal latches 0. Reset anywhere (mid-WB/FETCH) returns to IDLE on same edge, mem_req_o low next cycle, no fill/done issued.
- All outputs registered. States: IDLE, POLICY, WB, FETCH, FILL.
- IDLE, req_i&hit_i: next cycle policy_hit_o=1 for one cycle, policy_addr_o=hit_addr_i; stay IDLE.
- IDLE, req_i&!hit_i: latch set_i/tag_i; -> POLICY; policy_miss_o=1 first POLICY cycle only; policy_addr_o={0,set} throughout POLICY.
- POLICY: stays while policy_done_i=0 (no timeout). On policy_done_i=1: latch policy_addr_i, victim_tag_i, victim_dirty_i; -> WB if dirty else FETCH. Minimum one POLICY cycle.
- WB: mem_req_o=1, mem_rw_o=1, mem_addr_o={victim_tag,set}. On mem_ack_i -> FETCH.
- FETCH: mem_req_o=1, mem_rw_o=0, mem_addr_o={req_tag,set}. On mem_ack_i -> FILL. Each ack consumes exactly one request; ack accepted in the first request cycle; ack while mem_req_o=0 ignored.
- FILL: one cycle; fill_o=1, fill_addr_o=victim address, fill_tag_o=req tag, done_o=1; -> IDLE.
- busy_o=1 in every state except IDLE. req_i while busy_o=1 ignored (upstream stalls).
- Clean miss latency req_i -> done_o: 3 cycles + POLICY wait + memory wait.

Optional Feature:
N_SET_CACHE_MISS_SEQ_PERF_EN: adds outputs hit_count_o, miss_count_o, wb_count_o (32 bits each), saturating at 32'hFFFFFFFF, incremented on policy_hit_o, policy_miss_o, WB ack respectively; cleared by reset. Without macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
- Package n_set_cache_pkg: state enum (IDLE, POLICY, WB, FETCH, FILL), localparams BW_CACHE_CAPACITY/BW_GRP/BW_SET derivation.
- One sub-module: sat_counter (width parameter, increment, synchronous clear), used only under the perf macro.

Test Plan:
- Hit: req_i=1, hit_i=1, hit_addr_i=7'h25 -> next cycle policy_hit_o=1, policy_addr_o=7'h25, mem_req_o stays 0, busy_o=0.
- Clean miss: set_i=5'h03, tag_i=20'hABCDE, policy_done_i=1, policy_addr_i=7'h43, dirty=0, ack after 5 cycles -> mem_rw_o=0, mem_addr_o={20'hABCDE,5'h03}; fill_o with fill_addr_o=7'h43, fill_tag_o=20'hABCDE; done_o one cycle.
- Dirty miss: same plus victim_dirty_i=1, victim_tag_i=20'h12345 -> WB addr {20'h12345,5'h03} rw=1, after ack FETCH rw=0, then fill; exactly two acks consumed.
- Policy stall: policy_done_i low 3 cycles after miss -> policy_miss_o high only first cycle, no mem_req_o until done.
- Reset in FETCH: reset_i=1 one cycle -> IDLE, mem_req_o=0, no fill_o/done_o; subsequent hit serviced normally.
- With perf macro: 3 hits, 2 misses (1 dirty) -> hit_count_o=3, miss_count_o=2, wb_count_o=1; preload saturation -> holds 32'hFFFFFFFF.
